// File: rtl/ps2_cmd_decoder.sv
// PS/2 game-command decoder: key map, typematic/hold filter, 4-entry FWFT command queue, cursor tracker.
// Optional feature: define CURSOR_WRAP_EN to make cursor moves wrap at the board edges instead of saturating.
module ps2_cmd_decoder #(
    parameter int unsigned HOLD_CYCLES = 2500000,
    parameter int unsigned GRID        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    input  logic       key_valid,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic       overflow
);

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned POS_W   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FCNT_W  = 3;
    localparam int unsigned QUIET_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CMD_W-1:0] CMD_NONE    = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP      = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN    = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT    = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT   = 3'd4;
    localparam logic [CMD_W-1:0] CMD_FIRE    = 3'd5;
    localparam logic [CMD_W-1:0] CMD_ROTATE  = 3'd6;
    localparam logic [CMD_W-1:0] CMD_NEWGAME = 3'd7;

    localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(GRID - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(HOLD_CYCLES - 1);
    localparam logic [FCNT_W-1:0]  FIFO_FULL  = FCNT_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_t;

    function automatic logic [CMD_W-1:0] map_key(input logic [CODE_W-1:0] code);
        case (code)
            8'h1D, 8'h75: map_key = CMD_UP;
            8'h1B, 8'h72: map_key = CMD_DOWN;
            8'h1C, 8'h6B: map_key = CMD_LEFT;
            8'h23, 8'h74: map_key = CMD_RIGHT;
            8'h29, 8'h5A: map_key = CMD_FIRE;
            8'h2D:        map_key = CMD_ROTATE;
            8'h76:        map_key = CMD_NEWGAME;
            default:      map_key = CMD_NONE;
        endcase
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
`ifdef CURSOR_WRAP_EN
        pos_dec = (p == '0) ? POS_MAX : p - POS_W'(1);
`else
        pos_dec = (p == '0) ? p : p - POS_W'(1);
`endif
    endfunction

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
`ifdef CURSOR_WRAP_EN
        pos_inc = (p >= POS_MAX) ? '0 : p + POS_W'(1);
`else
        pos_inc = (p >= POS_MAX) ? POS_MAX : p + POS_W'(1);
`endif
    endfunction

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   held_code, held_code_nxt;
    logic [QUIET_W-1:0]  quiet_cnt, quiet_cnt_nxt;
    logic [CMD_W-1:0]    key_cmd;
    logic                key_mapped;
    logic                emit;

    logic [CMD_W-1:0]    mem [DEPTH];
    logic [CMD_W-1:0]    mem_nxt [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
    logic [FCNT_W-1:0]   fcount, fcount_nxt;
    logic [CMD_W-1:0]    head_nxt;
    logic                pop, push, drop;
    logic [POS_W-1:0]    cur_x_nxt, cur_y_nxt;

    always_comb begin
        key_cmd    = map_key(key);
        key_mapped = (key_cmd != CMD_NONE);
    end

    // Filter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            held_code <= '0;
            quiet_cnt <= '0;
        end else begin
            state     <= state_nxt;
            held_code <= held_code_nxt;
            quiet_cnt <= quiet_cnt_nxt;
        end
    end

    // Filter next state: leave HELD only after a full quiet window
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (key_valid && key_mapped) state_nxt = S_HELD;
            S_HELD: if (!key_valid && quiet_cnt == QUIET_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Filter outputs: repeats/echoes of the held code are swallowed and restart the window
    always_comb begin
        emit          = 1'b0;
        held_code_nxt = held_code;
        quiet_cnt_nxt = quiet_cnt;
        case (state)
            S_IDLE: begin
                if (key_valid && key_mapped) begin
                    emit          = 1'b1;
                    held_code_nxt = key;
                    quiet_cnt_nxt = '0;
                end
            end
            S_HELD: begin
                if (key_valid) begin
                    if (key == held_code) begin
                        quiet_cnt_nxt = '0;
                    end else if (key_mapped) begin
                        emit          = 1'b1;
                        held_code_nxt = key;
                        quiet_cnt_nxt = '0;
                    end
                end else if (quiet_cnt == QUIET_LAST) begin
                    quiet_cnt_nxt = '0;
                end else begin
                    quiet_cnt_nxt = quiet_cnt + QUIET_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Queue bookkeeping; a pop frees a slot for a same-cycle push even when full
    always_comb begin
        pop        = cmd_valid && cmd_ready;
        push       = emit && ((fcount != FIFO_FULL) || pop);
        drop       = emit && (fcount == FIFO_FULL) && !pop;
        mem_nxt    = mem;
        if (push) mem_nxt[wr_ptr] = key_cmd;
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        wr_ptr_nxt = wr_ptr + PTR_W'(push);
        fcount_nxt = fcount + FCNT_W'(push) - FCNT_W'(pop);
        head_nxt   = (fcount_nxt == '0) ? CMD_NONE : mem_nxt[rd_ptr_nxt];
    end

    // Cursor moves only for commands that actually enter the queue
    always_comb begin
        cur_x_nxt = cur_x;
        cur_y_nxt = cur_y;
        if (push) begin
            case (key_cmd)
                CMD_UP:      cur_y_nxt = pos_dec(cur_y);
                CMD_DOWN:    cur_y_nxt = pos_inc(cur_y);
                CMD_LEFT:    cur_x_nxt = pos_dec(cur_x);
                CMD_RIGHT:   cur_x_nxt = pos_inc(cur_x);
                CMD_NEWGAME: begin
                    cur_x_nxt = '0;
                    cur_y_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= CMD_NONE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fcount    <= '0;
            cmd       <= CMD_NONE;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
        end else begin
            mem       <= mem_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            fcount    <= fcount_nxt;
            cmd       <= head_nxt;
            cmd_valid <= (fcount_nxt != '0);
            overflow  <= drop;
            cur_x     <= cur_x_nxt;
            cur_y     <= cur_y_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: scoreboard of expected commands plus a cursor model.
module tb_ps2_cmd_decoder;

    localparam int HOLD = 100;
    localparam int EDGE = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key;
    logic       key_valid;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cur_x;
    logic [3:0] cur_y;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt  = 0;
    int mx = 0;
    int my = 0;
    logic [2:0] exp_q[$];

    ps2_cmd_decoder #(.HOLD_CYCLES(HOLD), .GRID(EDGE)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cur_x(cur_x), .cur_y(cur_y), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmd(input logic [7:0] k);
        logic [2:0] c;
        c = 3'd0;
        if (k == 8'h1D || k == 8'h75) c = 3'd1;
        if (k == 8'h1B || k == 8'h72) c = 3'd2;
        if (k == 8'h1C || k == 8'h6B) c = 3'd3;
        if (k == 8'h23 || k == 8'h74) c = 3'd4;
        if (k == 8'h29 || k == 8'h5A) c = 3'd5;
        if (k == 8'h2D) c = 3'd6;
        if (k == 8'h76) c = 3'd7;
        return c;
    endfunction

    function automatic int step(input int p, input int dir);
        int n;
        n = p + dir;
`ifdef CURSOR_WRAP_EN
        if (n < 0) n = EDGE - 1;
        if (n > EDGE - 1) n = 0;
`else
        if (n < 0) n = 0;
        if (n > EDGE - 1) n = EDGE - 1;
`endif
        return n;
    endfunction

    task automatic model_move(input logic [2:0] c);
        case (c)
            3'd1: my = step(my, -1);
            3'd2: my = step(my, 1);
            3'd3: mx = step(mx, -1);
            3'd4: mx = step(mx, 1);
            3'd7: begin mx = 0; my = 0; end
            default: ;
        endcase
    endtask

    // One-cycle strobe; exp_push says whether the filter and queue should accept it
    task automatic send_key(input logic [7:0] k, input bit exp_push);
        @(posedge clk);
        #1;
        key       = k;
        key_valid = 1'b1;
        if (exp_push) begin
            exp_q.push_back(ref_cmd(k));
            model_move(ref_cmd(k));
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, 32'(cur_x), 32'(mx));
        check({tag, "_y"}, 32'(cur_y), 32'(my));
    endtask

    // Scoreboard: every accepted pop must match the oldest expected command
    always @(negedge clk) begin
        if (overflow) ovf_cnt++;
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) check("pop_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
            else check("pop_cmd", 32'(cmd), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n     = 1'b0;
        key       = 8'h00;
        key_valid = 1'b0;
        cmd_ready = 1'b1;
        #3;
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check_cursor("rst_cur");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single UP at the top edge, popped immediately
        send_key(8'h1D, 1'b1);
        check("up_cmd", 32'(cmd), 32'd1);
        check("up_cmd_valid", 32'(cmd_valid), 32'd1);
        check_cursor("up_cur");
        idle(1);
        check("up_valid_one_cycle", 32'(cmd_valid), 32'd0);
        send_key(8'h99, 1'b0);
        check_cursor("unmapped_cur");
        idle(HOLD + 10);

        // Typematic repeats of a held key are swallowed
        send_key(8'h23, 1'b1);
        idle(9);
        send_key(8'h23, 1'b0);
        idle(9);
        send_key(8'h23, 1'b0);
        check("hold_cur_x", 32'(cur_x), 32'd1);
        idle(HOLD);
        send_key(8'h23, 1'b1);
        check("rehit_cur_x", 32'(cur_x), 32'd2);
        idle(HOLD + 10);

        // Fill the queue with the consumer stalled; fifth command overflows
        cmd_ready = 1'b0;
        ovf_cnt   = 0;
        send_key(8'h1D, 1'b1);
        send_key(8'h1B, 1'b1);
        send_key(8'h1C, 1'b1);
        send_key(8'h23, 1'b1);
        send_key(8'h29, 1'b0);
        idle(2);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        check("full_head", 32'(cmd), 32'd1);
        check("full_valid", 32'(cmd_valid), 32'd1);
        check_cursor("full_cur");
        cmd_ready = 1'b1;
        idle(6);
        check("drained_valid", 32'(cmd_valid), 32'd0);
        check("drained_q", 32'(exp_q.size()), 32'd0);
        idle(HOLD + 10);

        // Left edge: wrap or saturate
        send_key(8'h1C, 1'b1);
        send_key(8'h6B, 1'b1);
        check("x_at_zero", 32'(cur_x), 32'd0);
        send_key(8'h1C, 1'b1);
`ifdef CURSOR_WRAP_EN
        check("left_edge_x", 32'(cur_x), 32'd9);
`else
        check("left_edge_x", 32'(cur_x), 32'd0);
`endif
        send_key(8'h74, 1'b1);
        send_key(8'h75, 1'b1);
        send_key(8'h1D, 1'b1);
        check_cursor("edge_cur");
        idle(HOLD + 10);

        // Same key in separate windows, then NEWGAME homes the cursor
        send_key(8'h23, 1'b1);
        idle(HOLD + 10);
        send_key(8'h23, 1'b1);
        send_key(8'h76, 1'b1);
        check("newgame_x", 32'(cur_x), 32'd0);
        check("newgame_y", 32'(cur_y), 32'd0);
        idle(HOLD + 10);

        // Reset with commands queued discards them and the held key
        cmd_ready = 1'b0;
        send_key(8'h1D, 1'b1);
        send_key(8'h1B, 1'b1);
        send_key(8'h2D, 1'b1);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        exp_q.delete();
        mx = 0;
        my = 0;
        check_cursor("mid_rst_cur");
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_ready = 1'b1;
        send_key(8'h2D, 1'b1);
        check("post_rst_cmd", 32'(cmd), 32'd6);
        idle(4);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(cmd_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
